// File: rtl/hsi_mse_rt.sv
// hsi_mse_rt: streaming sum-of-squared-differences engine for two packed
// hyperspectral vectors, followed by a sequential divide by the band count.
// Optional best-match tracking is compiled in with `define HM_MIN_TRACK_EN.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for a start word; non-start words are dropped
//   S_ACC   | accepting the remaining words of the current vector
//   S_DRAIN | three cycles letting the datapath pipeline empty
//   S_DIV   | restoring divide SSE / bands, one quotient bit per cycle
//   S_OUT   | result presented, waiting for mse_ready
`timescale 1ns/1ps

module hsi_mse_rt #(
    parameter int WORD_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_WIDTH_MUL = 32,
    parameter int DATA_WIDTH_ACC = 48,
    parameter int HSI_BANDS      = 128,
    localparam int DATA_PER_WORD = WORD_WIDTH / DATA_WIDTH,
    localparam int BANDS_WIDTH   = $clog2(HSI_BANDS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BANDS_WIDTH-1:0] cfg_bands,
    input  logic                   start_vctr,
    input  logic [WORD_WIDTH-1:0]  element_a,
    input  logic [WORD_WIDTH-1:0]  element_b,
    input  logic                   element_valid,
    output logic                   element_ready,
    output logic [WORD_WIDTH-1:0]  mse,
    output logic                   mse_valid,
    input  logic                   mse_ready,
    output logic                   error
`ifdef HM_MIN_TRACK_EN
    ,
    input  logic                   min_clear,
    output logic [WORD_WIDTH-1:0]  min_mse,
    output logic [15:0]            min_idx,
    output logic                   min_valid
`endif
);

    localparam int CNT_W  = $clog2(DATA_WIDTH_ACC + 1);
    localparam int LANE_W = $clog2(DATA_PER_WORD + 1);

    typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_DIV, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic [BANDS_WIDTH-1:0]    bands_q, bands_d;
    logic [BANDS_WIDTH-1:0]    words_left_q, words_left_d;
    logic [LANE_W-1:0]         lanes_last_q, lanes_last_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH_ACC-1:0] dq_q, dq_d;
    logic [BANDS_WIDTH-1:0]    rem_q, rem_d;
    logic [WORD_WIDTH-1:0]     mse_q, mse_d;
    logic                      err_q, err_d;

    logic [DATA_WIDTH-1:0]     s1_diff_q [DATA_PER_WORD];
    logic                      s1_vld_q;
    logic [DATA_WIDTH_MUL-1:0] s2_sq_q [DATA_PER_WORD];
    logic                      s2_vld_q;
    logic [DATA_WIDTH_ACC-1:0] acc_q;

    logic                      xfer;
    logic                      take;
    logic                      flush;
    logic [LANE_W-1:0]         lane_lim;
    logic                      cfg_ok;
    logic [BANDS_WIDTH-1:0]    cfg_words;
    logic [LANE_W-1:0]         cfg_lanes_last;
    logic [BANDS_WIDTH:0]      rem_shift;
    logic                      rem_ge;
    logic [DATA_WIDTH-1:0]     diff_d [DATA_PER_WORD];
    logic [DATA_WIDTH_ACC-1:0] lane_sum;

    assign element_ready = rst_n && (state_q == S_IDLE || state_q == S_ACC);
    assign xfer          = element_valid && element_ready;
    assign mse_valid     = (state_q == S_OUT);
    assign mse           = mse_q;
    assign error         = err_q;

    // Decode the band count offered with a start word.
    always_comb begin
        cfg_ok         = (cfg_bands != '0) && (int'(cfg_bands) <= HSI_BANDS);
        cfg_words      = BANDS_WIDTH'((int'(cfg_bands) + DATA_PER_WORD - 1) / DATA_PER_WORD);
        cfg_lanes_last = LANE_W'(int'(cfg_bands) - (int'(cfg_words) - 1) * DATA_PER_WORD);
        rem_shift      = {rem_q, dq_q[DATA_WIDTH_ACC-1]};
        rem_ge         = (rem_shift >= {1'b0, bands_q});
    end

    // Sequencing: word acceptance, drain timer, divider steps, result hold.
    always_comb begin
        state_d      = state_q;
        bands_d      = bands_q;
        words_left_d = words_left_q;
        lanes_last_d = lanes_last_q;
        cnt_d        = cnt_q;
        dq_d         = dq_q;
        rem_d        = rem_q;
        mse_d        = mse_q;
        err_d        = 1'b0;
        take         = 1'b0;
        flush        = 1'b0;
        lane_lim     = LANE_W'(DATA_PER_WORD);
        case (state_q)
            S_IDLE, S_ACC: begin
                if (xfer) begin
                    if (start_vctr) begin
                        // A start word always begins from a clean accumulator;
                        // inside ACC it also signals an aborted vector.
                        flush = 1'b1;
                        if (state_q == S_ACC) err_d = 1'b1;
                        if (cfg_ok) begin
                            take         = 1'b1;
                            bands_d      = cfg_bands;
                            lanes_last_d = cfg_lanes_last;
                            words_left_d = cfg_words - 1'b1;
                            if (cfg_words == BANDS_WIDTH'(1)) begin
                                lane_lim = cfg_lanes_last;
                                cnt_d    = CNT_W'(2);
                                state_d  = S_DRAIN;
                            end else begin
                                state_d  = S_ACC;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (state_q == S_ACC) begin
                        take         = 1'b1;
                        words_left_d = words_left_q - 1'b1;
                        if (words_left_q == BANDS_WIDTH'(1)) begin
                            lane_lim = lanes_last_q;
                            cnt_d    = CNT_W'(2);
                            state_d  = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    dq_d    = acc_q;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(DATA_WIDTH_ACC);
                    state_d = S_DIV;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    // Quotient is complete; clamp anything wider than the output.
                    mse_d   = ((dq_q >> WORD_WIDTH) != '0) ? '1 : WORD_WIDTH'(dq_q);
                    state_d = S_OUT;
                end else begin
                    rem_d = rem_ge ? BANDS_WIDTH'(rem_shift - {1'b0, bands_q})
                                   : rem_shift[BANDS_WIDTH-1:0];
                    dq_d  = {dq_q[DATA_WIDTH_ACC-2:0], rem_ge};
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_OUT: begin
                if (mse_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bands_q      <= '0;
            words_left_q <= '0;
            lanes_last_q <= '0;
            cnt_q        <= '0;
            dq_q         <= '0;
            rem_q        <= '0;
            mse_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bands_q      <= bands_d;
            words_left_q <= words_left_d;
            lanes_last_q <= lanes_last_d;
            cnt_q        <= cnt_d;
            dq_q         <= dq_d;
            rem_q        <= rem_d;
            mse_q        <= mse_d;
            err_q        <= err_d;
        end
    end

    // Per-lane absolute difference with lanes past the band count zeroed,
    // plus the lane sum feeding the accumulator.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < DATA_PER_WORD; l++) begin
            logic [DATA_WIDTH-1:0] a_l, b_l;
            a_l       = element_a[l*DATA_WIDTH +: DATA_WIDTH];
            b_l       = element_b[l*DATA_WIDTH +: DATA_WIDTH];
            diff_d[l] = (a_l >= b_l) ? (a_l - b_l) : (b_l - a_l);
            if (LANE_W'(l) >= lane_lim) diff_d[l] = '0;
            lane_sum  = lane_sum + DATA_WIDTH_ACC'(s2_sq_q[l]);
        end
    end

    // Three-stage datapath: |a-b|, square, accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            acc_q    <= '0;
            for (int l = 0; l < DATA_PER_WORD; l++) begin
                s1_diff_q[l] <= '0;
                s2_sq_q[l]   <= '0;
            end
        end else begin
            s1_vld_q <= take;
            s2_vld_q <= s1_vld_q && !flush;
            for (int l = 0; l < DATA_PER_WORD; l++) begin
                s1_diff_q[l] <= diff_d[l];
                s2_sq_q[l]   <= DATA_WIDTH_MUL'(s1_diff_q[l]) * DATA_WIDTH_MUL'(s1_diff_q[l]);
            end
            if (flush)         acc_q <= '0;
            else if (s2_vld_q) acc_q <= acc_q + lane_sum;
        end
    end

`ifdef HM_MIN_TRACK_EN
    logic [15:0]           vec_idx_q;
    logic [WORD_WIDTH-1:0] min_mse_q;
    logic [15:0]           min_idx_q;
    logic                  min_valid_q;
    logic                  res_hs;

    assign res_hs    = mse_valid && mse_ready;
    assign min_mse   = min_mse_q;
    assign min_idx   = min_idx_q;
    assign min_valid = min_valid_q;

    // Track the smallest result seen; strict compare keeps the earlier index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx_q   <= '0;
            min_mse_q   <= '1;
            min_idx_q   <= '0;
            min_valid_q <= 1'b0;
        end else if (min_clear) begin
            vec_idx_q   <= '0;
            min_mse_q   <= '1;
            min_idx_q   <= '0;
            min_valid_q <= 1'b0;
        end else if (res_hs) begin
            vec_idx_q <= vec_idx_q + 1'b1;
            if (!min_valid_q || mse_q < min_mse_q) begin
                min_mse_q   <= mse_q;
                min_idx_q   <= vec_idx_q;
                min_valid_q <= 1'b1;
            end
        end
    end
`endif

endmodule
